// File: rtl/rtc_bus_reader.sv
// rtc_bus_reader: drives one register read on a multiplexed RTC address/data bus.
// The address is written under wr_n, the bus is turned around, the data byte is
// read under rd_n, and cs_n then stays high for a recovery gap. Every output is
// a flop. Each flop loads the value that belongs to the state being entered, so
// the outputs change on the same edge as the state.
module rtc_bus_reader #(
    parameter int unsigned T_PHASE = 4,  // strobe low time in cycles, 1..255
    parameter int unsigned T_GAP   = 2   // recovery cycles after a read, 1..255
) (
    input  logic       clk,
    input  logic       reset,     // synchronous, active-low
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       cs_n,
    output logic       ad_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic [7:0] data_out,
    output logic       done,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, SETUP, ADDR_WR, HOLD, TURN, DATA_RD, RECOVER
    } state_t;

    // The counter counts down to zero, so it is loaded with length-1.
    localparam logic [7:0] PHASE_LAST = 8'(T_PHASE - 1);
    localparam logic [7:0] GAP_LAST   = 8'(T_GAP - 1);

    state_t     state_q,    state_d;
    logic [7:0] cnt_q,      cnt_d;
    logic [7:0] bus_out_q,  bus_out_d;
    logic [7:0] data_out_q, data_out_d;
    logic       bus_oe_q,   bus_oe_d;
    logic       cs_n_q,     cs_n_d;
    logic       ad_n_q,     ad_n_d;
    logic       wr_n_q,     wr_n_d;
    logic       rd_n_q,     rd_n_d;
    logic       done_q,     done_d;
    logic       busy_q,     busy_d;

    // Next-state, phase counter and data registers.
    always_comb begin
        // NOTE: every signal gets a default before the case; a path that skips
        // an assignment would otherwise infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        bus_out_d  = bus_out_q;   // also keeps the last address while bus_oe=0
        data_out_d = data_out_q;  // stable between done pulses
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SETUP;
                    bus_out_d = addr;  // the address is captured only here
                end
            end
            SETUP: begin
                state_d = ADDR_WR;
                cnt_d   = PHASE_LAST;
            end
            ADDR_WR: begin
                if (cnt_q == 8'd0) state_d = HOLD;
                else               cnt_d   = cnt_q - 8'd1;
            end
            HOLD:    state_d = TURN;
            TURN: begin
                state_d = DATA_RD;
                cnt_d   = PHASE_LAST;
            end
            DATA_RD: begin
                if (cnt_q == 8'd0) begin
                    state_d    = RECOVER;
                    cnt_d      = GAP_LAST;
                    data_out_d = bus_in;  // sampled at the end of the last strobe cycle
                    done_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RECOVER: begin
                if (cnt_q == 8'd0) state_d = IDLE;
                else               cnt_d   = cnt_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus control values for the state being entered (idle values by default).
    always_comb begin
        cs_n_d   = 1'b1;
        ad_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        bus_oe_d = 1'b0;
        busy_d   = (state_d != IDLE);
        case (state_d)
            SETUP, HOLD: begin
                cs_n_d   = 1'b0;
                ad_n_d   = 1'b0;
                bus_oe_d = 1'b1;
            end
            ADDR_WR: begin
                cs_n_d   = 1'b0;
                ad_n_d   = 1'b0;
                bus_oe_d = 1'b1;
                wr_n_d   = 1'b0;
            end
            TURN:    cs_n_d = 1'b0;
            DATA_RD: begin
                cs_n_d = 1'b0;
                rd_n_d = 1'b0;
            end
            default: ;
        endcase
    end

    // State and output registers. A reset aborts any transaction on this edge
    // and ignores start.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so that every
        // flop samples the pre-edge values, whatever order the statements are in.
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            bus_out_q  <= 8'h00;
            data_out_q <= 8'h00;
            bus_oe_q   <= 1'b0;
            cs_n_q     <= 1'b1;
            ad_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bus_out_q  <= bus_out_d;
            data_out_q <= data_out_d;
            bus_oe_q   <= bus_oe_d;
            cs_n_q     <= cs_n_d;
            ad_n_q     <= ad_n_d;
            wr_n_q     <= wr_n_d;
            rd_n_q     <= rd_n_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign bus_out  = bus_out_q;
    assign bus_oe   = bus_oe_q;
    assign cs_n     = cs_n_q;
    assign ad_n     = ad_n_q;
    assign wr_n     = wr_n_q;
    assign rd_n     = rd_n_q;
    assign data_out = data_out_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_rtc_bus_reader.sv
// tb_rtc_bus_reader: directed bench for rtc_bus_reader. Instance dut uses the
// default timing (4/2) and instance dut_f uses the fastest timing (1/1).
// Cycle c is the interval after the c-th rising edge that follows the cycle in
// which start was driven (cycle 0). Outputs are sampled 1 ns after an edge.
module tb_rtc_bus_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start,   start_f;
    logic [7:0] addr,    addr_f;
    logic [7:0] bus_in,  bus_in_f;
    logic [7:0] bus_out, bus_out_f, data_out, data_out_f;
    logic       bus_oe, cs_n, ad_n, wr_n, rd_n, done, busy;
    logic       bus_oe_f, cs_n_f, ad_n_f, wr_n_f, rd_n_f, done_f, busy_f;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;
    bit run_mon  = 1'b1;

    always #5 clk = ~clk;

    rtc_bus_reader #(.T_PHASE(4), .T_GAP(2)) dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .bus_in(bus_in),
        .bus_out(bus_out), .bus_oe(bus_oe), .cs_n(cs_n), .ad_n(ad_n),
        .wr_n(wr_n), .rd_n(rd_n), .data_out(data_out), .done(done), .busy(busy)
    );

    rtc_bus_reader #(.T_PHASE(1), .T_GAP(1)) dut_f (
        .clk(clk), .reset(reset), .start(start_f), .addr(addr_f), .bus_in(bus_in_f),
        .bus_out(bus_out_f), .bus_oe(bus_oe_f), .cs_n(cs_n_f), .ad_n(ad_n_f),
        .wr_n(wr_n_f), .rd_n(rd_n_f), .data_out(data_out_f), .done(done_f), .busy(busy_f)
    );

    // Control outputs packed in the order {cs_n, ad_n, wr_n, rd_n, bus_oe, done, busy}.
    typedef struct packed {
        logic cs_n, ad_n, wr_n, rd_n, oe, done, busy;
    } ctrl_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected control outputs in cycle c for a start accepted in cycle 0:
    // SETUP is cycle 1, ADDR_WR 2..1+tp, HOLD 2+tp, TURN 3+tp, DATA_RD
    // 4+tp..3+2tp, RECOVER 4+2tp..3+2tp+tg, then IDLE.
    function automatic ctrl_t model(input int c, input int tp, input int tg);
        ctrl_t e;
        e.cs_n = !(c >= 1 && c <= 3 + 2 * tp);
        e.ad_n = !(c >= 1 && c <= 2 + tp);
        e.oe   =  (c >= 1 && c <= 2 + tp);
        e.wr_n = !(c >= 2 && c <= 1 + tp);
        e.rd_n = !(c >= 4 + tp && c <= 3 + 2 * tp);
        e.done =  (c == 4 + 2 * tp);
        e.busy =  (c >= 1 && c <= 3 + 2 * tp + tg);
        return e;
    endfunction

    // Bus safety rules on both instances, every cycle.
    always @(negedge clk) begin
        if (run_mon) begin
            check("wr_rd_overlap",   {31'd0, !wr_n && !rd_n},       32'd0);
            check("oe_during_rd",    {31'd0, bus_oe && !rd_n},      32'd0);
            check("strobe_no_cs",    {31'd0, (!wr_n || !rd_n) && cs_n}, 32'd0);
            check("f_wr_rd_overlap", {31'd0, !wr_n_f && !rd_n_f},   32'd0);
            check("f_oe_during_rd",  {31'd0, bus_oe_f && !rd_n_f},  32'd0);
            check("f_strobe_no_cs",  {31'd0, (!wr_n_f || !rd_n_f) && cs_n_f}, 32'd0);
        end
    end

    initial begin
        int done_cnt, first_done, second_done;

        reset = 1'b0; start = 1'b1; addr = 8'h99; bus_in = 8'hEE;
        start_f = 1'b0; addr_f = 8'h00; bus_in_f = 8'h00;

        // Reset state; start is held high to show it is ignored under reset.
        repeat (3) step();
        check("rst_ctrl", {25'd0, cs_n, ad_n, wr_n, rd_n, bus_oe, done, busy}, 32'b1111000);
        check("rst_bus_out",  bus_out,  8'h00);
        check("rst_data_out", data_out, 8'h00);
        start = 1'b0;
        reset = 1'b1;
        step();
        check("rst_release_idle", busy, 1'b0);

        // Single read: addr 0x21, bus_in 0x59.
        addr = 8'h21; bus_in = 8'h59; start = 1'b1; cyc = 0;
        for (int c = 1; c <= 15; c++) begin
            step();
            if (c == 1) start = 1'b0;
            check($sformatf("single_ctrl_c%0d", c),
                  {25'd0, cs_n, ad_n, wr_n, rd_n, bus_oe, done, busy}, model(c, 4, 2));
            if (c <= 6)  check($sformatf("single_bus_out_c%0d", c), bus_out, 8'h21);
            if (c == 12) check("single_data", data_out, 8'h59);
        end

        // Start held high throughout, addr changed mid-transaction.
        addr = 8'h05; bus_in = 8'h77; start = 1'b1; cyc = 0; done_cnt = 0;
        for (int c = 1; c <= 15; c++) begin
            step();
            if (c == 2) addr = 8'hAA;
            if (done) done_cnt++;
            if (c <= 13) begin
                check($sformatf("hold_busy_c%0d", c), busy, 1'b1);
                check($sformatf("hold_addr_c%0d", c), bus_out, 8'h05);
            end
            if (c == 14) begin
                check("hold_idle_gap", busy, 1'b0);
                check("hold_one_done", done_cnt, 1);
            end
            if (c == 15) begin
                check("hold_second_busy", busy, 1'b1);
                check("hold_second_addr", bus_out, 8'hAA);
            end
        end
        start = 1'b0;
        repeat (14) step();
        check("hold_second_end", busy, 1'b0);
        check("hold_second_data", data_out, 8'h77);

        // Reset asserted in cycle 9, in the middle of DATA_RD.
        addr = 8'h40; bus_in = 8'h3C; start = 1'b1; cyc = 0;
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c == 1) start = 1'b0;
        end
        check("mid_rd_strobe", rd_n, 1'b0);
        check("mid_data_stable", data_out, 8'h77);
        reset = 1'b0;
        step();
        check("abort_ctrl", {25'd0, cs_n, ad_n, wr_n, rd_n, bus_oe, done, busy}, 32'b1111000);
        check("abort_data", data_out, 8'h00);
        check("abort_bus_out", bus_out, 8'h00);
        reset = 1'b1;
        done_cnt = 0;
        for (int c = 11; c <= 16; c++) begin
            step();
            if (done || busy) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);

        // Back-to-back reads: 0x00 -> 0x12, then 0x0F -> 0x34 from the first IDLE cycle.
        addr = 8'h00; bus_in = 8'h12; start = 1'b1; cyc = 0;
        first_done = -1; second_done = -1;
        for (int c = 1; c <= 28; c++) begin
            step();
            if (c == 1)  start = 1'b0;
            if (c == 13) bus_in = 8'h34;
            if (c == 14) begin start = 1'b1; addr = 8'h0F; end
            if (c == 15) start = 1'b0;
            if (done) begin
                if (first_done < 0) first_done = c;
                else                second_done = c;
            end
            if (c == 12) check("b2b_data1", data_out, 8'h12);
            if (c == 20) check("b2b_data1_stable", data_out, 8'h12);
            if (c == 15) check("b2b_addr2", bus_out, 8'h0F);
            if (c == 26) check("b2b_data2", data_out, 8'h34);
        end
        check("b2b_done1_cycle", first_done, 12);
        check("b2b_done2_cycle", second_done, 26);

        // Fastest timing: T_PHASE=1, T_GAP=1.
        addr_f = 8'h5A; bus_in_f = 8'hC3; start_f = 1'b1; cyc = 0;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) start_f = 1'b0;
            check($sformatf("fast_ctrl_c%0d", c),
                  {25'd0, cs_n_f, ad_n_f, wr_n_f, rd_n_f, bus_oe_f, done_f, busy_f}, model(c, 1, 1));
            if (c == 6) check("fast_data", data_out_f, 8'hC3);
        end

        run_mon = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rtc_bus_reader.md
RTC_BUS_READER -- requirements
Module: rtc_bus_reader

Interface
REQ-001 SHALL have parameter T_PHASE, default 4: cycles each strobe (wr_n, rd_n) is held low; legal range 1..255.
REQ-002 SHALL have parameter T_GAP, default 2: recovery cycles with cs_n high after a read; legal range 1..255.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  read request; sampled only when busy=0.
REQ-006 SHALL have port addr  input  8  RTC register address; captured on an accepted start.
REQ-007 SHALL have port bus_in  input  8  value currently present on the shared RTC address/data bus.
REQ-008 SHALL have port bus_out  output  8  address value the external tristate buffer drives onto the bus.
REQ-009 SHALL have port bus_oe  output  1  enable for that tristate buffer; 1 = drive bus_out, 0 = high-Z.
REQ-010 SHALL have port cs_n  output  1  RTC chip select, active-low.
REQ-011 SHALL have port ad_n  output  1  address/data select: 0 = address phase, 1 = data phase.
REQ-012 SHALL have port wr_n  output  1  RTC write strobe, active-low.
REQ-013 SHALL have port rd_n  output  1  RTC read strobe, active-low.
REQ-014 SHALL have port data_out  output  8  last byte read from the RTC.
REQ-015 SHALL have port done  output  1  one-cycle pulse; data_out valid.
REQ-016 SHALL have port busy  output  1  high while a transaction is in progress.

Function
REQ-017 SHALL drive all outputs from registers, with no combinational path from any input to any output.
REQ-018 SHALL implement the FSM IDLE -> SETUP -> ADDR_WR -> HOLD -> TURN -> DATA_RD -> RECOVER -> IDLE.
REQ-019 SHALL use an 8-bit phase counter to time ADDR_WR, DATA_RD and RECOVER.
REQ-020 SHALL accept start=1 in IDLE (cycle 0), capture addr, and enter SETUP in cycle 1, with busy=1 from cycle 1.
REQ-021 SHALL hold SETUP for 1 cycle with: cs_n=0, ad_n=0, bus_oe=1, bus_out=captured addr, wr_n=1, rd_n=1.
REQ-022 SHALL hold ADDR_WR for T_PHASE cycles (cycles 2..1+T_PHASE) with wr_n=0 and all SETUP values otherwise unchanged.
REQ-023 SHALL hold HOLD for 1 cycle with wr_n=1, bus_oe=1 and ad_n=0 still asserted.
REQ-024 SHALL hold TURN for 1 cycle with bus_oe=0, ad_n=1, rd_n=1 and cs_n=0.
REQ-025 SHALL hold DATA_RD for T_PHASE cycles with rd_n=0, bus_oe=0 and ad_n=1.
REQ-026 SHALL capture bus_in into data_out at the end of the last DATA_RD cycle.
REQ-027 SHALL, on entering RECOVER, set rd_n=1 and cs_n=1 and pulse done=1 for exactly that first cycle.
REQ-028 SHALL hold RECOVER for T_GAP cycles and then return to IDLE with busy=0.
REQ-029 SHALL produce, for an accepted start in cycle 0: done=1 in cycle 4+2*T_PHASE, and busy=0 from cycle 4+2*T_PHASE+T_GAP.
REQ-030 SHALL ignore start while busy=1, neither queuing nor aborting the transaction; addr changes during a transaction SHALL have no effect.
REQ-031 SHALL never have wr_n=0 and rd_n=0 in the same cycle.
REQ-032 SHALL never have bus_oe=1 while rd_n=0.
REQ-033 SHALL, in the RECOVER-to-IDLE cycle, accept start=1 as a new request on the first IDLE cycle (no back-to-back overlap).
REQ-034 SHALL hold data_out stable between done pulses.
REQ-035 SHALL hold bus_out at its last value when bus_oe=0.

Reset
REQ-036 SHALL, with reset=0 at a rising edge, force: state=IDLE, counter=0, cs_n=1, ad_n=1, wr_n=1, rd_n=1, bus_oe=0, bus_out=0x00, data_out=0x00, done=0, busy=0.
REQ-037 SHALL, on reset in any state (including mid-strobe), abort the transaction immediately with no done pulse; the bus is released the next cycle.
REQ-038 SHALL ignore start while reset=0.

Verification
REQ-039 SHALL check a single read: T_PHASE=4, T_GAP=2, addr=0x21, bus_in=0x59 during DATA_RD -> wr_n low in cycles 2-5; rd_n low in cycles 8-11; done in cycle 12 with data_out=0x59; busy=0 at cycle 14.
REQ-040 SHALL check start asserted on every cycle during a transaction -> exactly one transaction; a second begins only from the first IDLE cycle.
REQ-041 SHALL check reset=0 in cycle 9 (mid DATA_RD) -> from cycle 10 all strobes are high, bus_oe=0 and data_out=0x00, with no done pulse.
REQ-042 SHALL check back-to-back reads of addr 0x00 then 0x0F, with bus_in 0x12 then 0x34 -> done pulses 14 cycles apart, data_out 0x12 then 0x34.
REQ-043 SHALL check T_PHASE=1, T_GAP=1 -> done in cycle 6 and busy=0 at cycle 7.
REQ-044 SHALL check, on every cycle, that the assertions of REQ-031 and REQ-032 hold and that cs_n=0 whenever wr_n=0 or rd_n=0.
